beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Plays short, fixed tone patterns on the `buzzer` PWM block for the three calculator events: keypress click, result OK, and error. The block sits between the key/ALU control logic and `buzzer`. It turns single-cycle event requests into a timed sequence of `idx`/`en` values. It arbitrates competing requests by priority (error > OK > key).

## Interface
- `STEP_TICKS`, default 2_000_000: clock cycles per note step (40 ms at 50 MHz).
- `GAP_TICKS`, default 500_000: silent cycles after every note (10 ms).
- `clk` input 1: system clock, ~50 MHz; also drives `buzzer`.
- `rst` input 1: reset, asynchronous and active-high.
- `key_req` input 1: keypress click request; a single-cycle pulse.
- `ok_req` input 1: result-OK request; a single-cycle pulse.
- `err_req` input 1: error request; a single-cycle pulse.
- `idx` output 4: note index to `buzzer.idx`; registered.
- `en` output 1: tone enable to `buzzer.en`; registered.
- `busy` output 1: high while any pattern, including its final gap, is playing.

## Operation
- Pattern ROM (note idx × steps):
  - KEY = {12×1}.
  - OK = {4×2, 6×2, 8×2}.
  - ERR = {2×3, 0×3}.
- Priorities: ERR = 3, OK = 2, KEY = 1.
- FSM states:
  - IDLE: `en` = 0, `busy` = 0.
  - TONE: `en` = 1, `idx` = current note.
  - GAP: `en` = 0, `idx` holds the last note.
- Transitions:
  - IDLE → TONE on any request; the highest-priority request present that cycle wins, and the others are discarded.
  - TONE → GAP after steps×`STEP_TICKS` cycles.
  - GAP → TONE (next note) after `GAP_TICKS` cycles.
  - GAP → IDLE after the last note's gap, unless a pending request exists; in that case GAP → TONE with the first note of the pending pattern, and the pending register is cleared.
- Request arriving while busy:
  - Strictly higher priority than the playing pattern: preempt. Restart at note 0 of the new pattern on the next edge, zero the tick counter, and clear any pending request whose priority is ≤ the new one.
  - Equal or lower priority: handled per Configuration.
- Re-request of the pattern currently playing never restarts it.
- Counters:
  - Tick counter is `$clog2(max(STEP_TICKS*3, GAP_TICKS))` bits wide and counts from 0 up to limit−1.
  - Note pointer is 2 bits.
  - No wrap-around is visible outside the block.

## Timing
- Reset values: `idx` = 0, `en` = 0, `busy` = 0, FSM in IDLE, counters 0, pending cleared. Reset takes effect immediately (asynchronous), including mid-note; the buzzer is silent within the same cycle.
- Latency: a request sampled at edge N gives `en` = 1, first `idx`, and `busy` = 1 after edge N; 1 cycle.
- Each note holds `en` = 1 for exactly steps×`STEP_TICKS` cycles, followed by exactly `GAP_TICKS` cycles of `en` = 0.
- Total `busy` time per pattern = Σ(steps×`STEP_TICKS` + `GAP_TICKS`).
- `busy` falls on the edge the FSM enters IDLE. A request in that same cycle is accepted (IDLE → TONE next edge, with no idle bubble visible on `busy` if taken from pending).
- Preemption takes effect on the edge after the request; the new note's full duration counts from that edge.

## Configuration
- `BEEP_SEQ_PENDING_EN` defined: one-deep pending register. Equal/lower-priority OK or ERR requests received while busy are stored, and the highest-priority one is kept. KEY requests are never pended. The stored pattern plays immediately after the current pattern's final gap.
- `BEEP_SEQ_PENDING_EN` undefined: all non-preempting requests received while busy are dropped. No pending register is synthesized.

## Test plan
All scenarios use `STEP_TICKS` = 4 and `GAP_TICKS` = 2.
- Reset, then a single `key_req` → `en` = 1 for 4 cycles with `idx` = 12, then `en` = 0 for 2 cycles; `busy` high for 6 cycles, then IDLE.
- `ok_req` → `idx` sequence 4, 6, 8; each note has 8 cycles of `en` = 1 followed by a 2-cycle gap; `busy` high for 30 cycles.
- `key_req` + `ok_req` + `err_req` in the same cycle → ERR plays (2×12 on, gaps of 2; `busy` 28 cycles); KEY and OK never play.
- `ok_req`, then `err_req` 5 cycles later → on the next edge `idx` = 2, `en` = 1, 12-cycle note; ERR completes normally.
- With `BEEP_SEQ_PENDING_EN` defined: `err_req`, then `ok_req` during the ERR pattern → OK starts on the edge the final gap ends; `busy` stays high continuously for 58 cycles. Without the macro: OK is dropped and `busy` is high for 28 cycles.
- Assert `rst` mid-note during OK → `en`, `busy`, and `idx` are 0 immediately. After release, a `key_req` plays a normal 6-cycle KEY pattern.

Source files
------------

// File: rtl/beep_sequencer_if.sv
// rtl/beep_sequencer_if.sv - event request and buzzer drive bundle between control logic and beep_sequencer
interface beep_sequencer_if;
    logic       key_req;
    logic       ok_req;
    logic       err_req;
    logic [3:0] idx;
    logic       en;
    logic       busy;

    modport master (
        output key_req, ok_req, err_req,
        input  idx, en, busy
    );

    modport slave (
        input  key_req, ok_req, err_req,
        output idx, en, busy
    );
endinterface

// File: rtl/beep_sequencer.sv
// rtl/beep_sequencer.sv - prioritised tone-pattern player (KEY/OK/ERR) driving buzzer idx/en
// Optional one-deep pending request register enabled by BEEP_SEQ_PENDING_EN.
module beep_sequencer #(
    parameter int STEP_TICKS = 2_000_000,
    parameter int GAP_TICKS  = 500_000
) (
    input  logic            clk,
    input  logic            rst,
    beep_sequencer_if.slave bus
);
    localparam int CNT_MAX = (STEP_TICKS * 3 > GAP_TICKS) ? STEP_TICKS * 3 : GAP_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Pattern codes double as priorities, so a plain compare arbitrates.
    localparam logic [1:0] PAT_NONE = 2'd0;
    localparam logic [1:0] PAT_KEY  = 2'd1;
    localparam logic [1:0] PAT_OK   = 2'd2;
    localparam logic [1:0] PAT_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TONE,
        ST_GAP
    } state_t;

    state_t           state_q;
    logic [1:0]       pat_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       idx_q;
    logic             en_q;
    logic             busy_q;
`ifdef BEEP_SEQ_PENDING_EN
    logic [1:0]       pend_q;
    logic [1:0]       cand_pat;
`endif

    logic [1:0] req_pat;
    logic [1:0] pend_d;
    logic [1:0] start_pat;
    logic       tone_end;
    logic       gap_end;
    logic       last_note;
    int         tone_len;

    function automatic logic [3:0] rom_idx(input logic [1:0] pat, input logic [1:0] ptr);
        logic [3:0] r;
        case ({pat, ptr})
            {PAT_KEY, 2'd0}: r = 4'd12;
            {PAT_OK,  2'd0}: r = 4'd4;
            {PAT_OK,  2'd1}: r = 4'd6;
            {PAT_OK,  2'd2}: r = 4'd8;
            {PAT_ERR, 2'd0}: r = 4'd2;
            {PAT_ERR, 2'd1}: r = 4'd0;
            default:         r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] rom_steps(input logic [1:0] pat);
        logic [1:0] r;
        case (pat)
            PAT_KEY: r = 2'd1;
            PAT_OK:  r = 2'd2;
            PAT_ERR: r = 2'd3;
            default: r = 2'd1;
        endcase
        return r;
    endfunction

    function automatic logic rom_last(input logic [1:0] pat, input logic [1:0] ptr);
        logic r;
        case (pat)
            PAT_KEY: r = (ptr == 2'd0);
            PAT_OK:  r = (ptr == 2'd2);
            PAT_ERR: r = (ptr == 2'd1);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        req_pat = bus.err_req ? PAT_ERR :
                  bus.ok_req  ? PAT_OK  :
                  bus.key_req ? PAT_KEY : PAT_NONE;
`ifdef BEEP_SEQ_PENDING_EN
        // KEY clicks are never worth queueing; only OK/ERR compete for the slot.
        cand_pat = bus.err_req ? PAT_ERR : bus.ok_req ? PAT_OK : PAT_NONE;
        pend_d   = (cand_pat > pend_q) ? cand_pat : pend_q;
`else
        pend_d   = PAT_NONE;
`endif
        tone_len  = int'(rom_steps(pat_q)) * STEP_TICKS;
        tone_end  = (int'(cnt_q) == tone_len - 1);
        gap_end   = (int'(cnt_q) == GAP_TICKS - 1);
        last_note = rom_last(pat_q, ptr_q);

        start_pat = PAT_NONE;
        if (state_q == ST_IDLE) begin
            start_pat = req_pat;
        end else if (req_pat > pat_q) begin
            start_pat = req_pat;
        end else if (state_q == ST_GAP && gap_end && last_note) begin
            start_pat = pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_NONE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BEEP_SEQ_PENDING_EN
            pend_q  <= PAT_NONE;
`endif
        end else if (start_pat != PAT_NONE) begin
            // Covers a fresh start, a preempt and the hand-off from pending.
            state_q <= ST_TONE;
            pat_q   <= start_pat;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            idx_q   <= rom_idx(start_pat, 2'd0);
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
`ifdef BEEP_SEQ_PENDING_EN
            pend_q  <= PAT_NONE;
`endif
        end else begin
`ifdef BEEP_SEQ_PENDING_EN
            pend_q <= pend_d;
`endif
            case (state_q)
                ST_IDLE: begin
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
                ST_TONE: begin
                    if (tone_end) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        cnt_q <= '0;
                        if (last_note) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_TONE;
                            ptr_q   <= ptr_q + 2'd1;
                            idx_q   <= rom_idx(pat_q, ptr_q + 2'd1);
                            en_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.idx  = idx_q;
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_beep_sequencer.sv
// tb/tb_beep_sequencer.sv - scoreboard bench for beep_sequencer (notes and busy spans)
module tb_beep_sequencer;
    localparam int STEP = 4;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    beep_sequencer_if bif ();

    beep_sequencer #(.STEP_TICKS(STEP), .GAP_TICKS(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_note_q[$];
    int exp_busy_q[$];

    logic [3:0] cur_idx = 4'd0;
    bit         in_note = 1'b0;
    bit         prev_en = 1'b0;
    int         on_cnt  = 0;
    int         gap_cnt = 0;
    int         busy_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pk(input int i, input int on, input int gap);
        return (i << 16) | (on << 8) | gap;
    endfunction

    task automatic close_note();
        if (exp_note_q.size() == 0)
            chk("note_unexpected", pk(int'(cur_idx), on_cnt, gap_cnt), 0);
        else
            chk("note", pk(int'(cur_idx), on_cnt, gap_cnt), exp_note_q.pop_front());
        in_note = 1'b0;
    endtask

    task automatic push_note(input int i, input int on, input int gap);
        exp_note_q.push_back(pk(i, on, gap));
    endtask

    // Note/busy monitor: a note opens on en rising or idx changing while en is high.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_note  = 1'b0;
                busy_run = 0;
                prev_en  = 1'b0;
            end else begin
                if (bif.en && (!in_note || !prev_en || bif.idx != cur_idx)) begin
                    if (in_note) close_note();
                    cur_idx = bif.idx;
                    on_cnt  = 1;
                    gap_cnt = 0;
                    in_note = 1'b1;
                end else if (bif.en) begin
                    on_cnt++;
                end else if (in_note && bif.busy) begin
                    gap_cnt++;
                end else if (in_note) begin
                    close_note();
                end
                if (bif.busy) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    if (exp_busy_q.size() == 0) chk("busy_unexpected", busy_run, 0);
                    else chk("busy_len", busy_run, exp_busy_q.pop_front());
                    busy_run = 0;
                end
                prev_en = bif.en;
            end
        end
    end

    task automatic pulse(input bit k, input bit o, input bit e);
        @(negedge clk);
        bif.key_req = k;
        bif.ok_req  = o;
        bif.err_req = e;
        @(negedge clk);
        bif.key_req = 1'b0;
        bif.ok_req  = 1'b0;
        bif.err_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bif.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(bif.busy), 0);
        repeat (3) @(negedge clk);
        chk({tag, "_notes_left"}, exp_note_q.size(), 0);
        chk({tag, "_busy_left"}, exp_busy_q.size(), 0);
    endtask

    task automatic push_key();
        push_note(12, 4, 2);
        exp_busy_q.push_back(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.key_req = 1'b0;
        bif.ok_req  = 1'b0;
        bif.err_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_idx", bif.idx, 0);
        chk("rst_en", bif.en, 0);
        chk("rst_busy", bif.busy, 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Single key click, with one-cycle latency check
        push_key();
        pulse(1, 0, 0);
        chk("key_lat_en", bif.en, 1);
        chk("key_lat_idx", bif.idx, 12);
        chk("key_lat_busy", bif.busy, 1);
        wait_idle("key");

        // OK pattern
        push_note(4, 8, 2);
        push_note(6, 8, 2);
        push_note(8, 8, 2);
        exp_busy_q.push_back(30);
        pulse(0, 1, 0);
        wait_idle("ok");

        // All three together: only ERR plays
        push_note(2, 12, 2);
        push_note(0, 12, 2);
        exp_busy_q.push_back(28);
        pulse(1, 1, 1);
        wait_idle("prio");

        // ERR preempts OK five cycles into its first note
        push_note(4, 5, 0);
        push_note(2, 12, 2);
        push_note(0, 12, 2);
        exp_busy_q.push_back(33);
        pulse(0, 1, 0);
        repeat (3) @(negedge clk);
        pulse(0, 0, 1);
        chk("preempt_idx", bif.idx, 2);
        chk("preempt_en", bif.en, 1);
        wait_idle("preempt");

        // OK (plus a key click) requested during ERR
        push_note(2, 12, 2);
        push_note(0, 12, 2);
`ifdef BEEP_SEQ_PENDING_EN
        push_note(4, 8, 2);
        push_note(6, 8, 2);
        push_note(8, 8, 2);
        exp_busy_q.push_back(58);
`else
        exp_busy_q.push_back(28);
`endif
        pulse(0, 0, 1);
        repeat (8) @(negedge clk);
        pulse(1, 1, 0);
        wait_idle("pend");

        // Asynchronous reset in the middle of an OK note
        push_note(4, 8, 2);
        exp_busy_q.push_back(30);
        pulse(0, 1, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_en", bif.en, 0);
        chk("arst_busy", bif.busy, 0);
        chk("arst_idx", bif.idx, 0);
        exp_note_q.delete();
        exp_busy_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        push_key();
        pulse(1, 0, 0);
        wait_idle("post_rst_key");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
